adder_bist_checker: RTL and testbench



---
 rtl/adder_bist_defs.sv | 21 ++
 rtl/adder_vector_gen.sv | 47 ++++
 rtl/adder_bist_checker.sv | 162 ++++++++++++++++
 tb/tb_adder_bist_checker.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/adder_bist_defs.sv
// Shared definitions for the adder self-check engine: FSM state encoding,
// default widths and the sweep vector-count helper.
package adder_bist_defs;

  // Sweep controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } bist_state_e;

  // Error counter width used when the instantiator does not override it.
  localparam int DEFAULT_ERR_W = 16;

  // Number of vectors in one sweep: every {cin, a, b} combination.
  function automatic int vector_count(input int sweep_bits);
    return 1 << (2 * sweep_bits + 1);
  endfunction

endpackage

// File: rtl/adder_vector_gen.sv
// Sweep index generator. The index is {cin, a, b} with b in the low bits,
// so incrementing it walks b fastest, then a, then cin.
module adder_vector_gen
  import adder_bist_defs::*;
#(
  parameter int SWEEP_BITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_i,
  input  logic                  advance_i,
  output logic [SWEEP_BITS-1:0] a_o,
  output logic [SWEEP_BITS-1:0] b_o,
  output logic                  cin_o,
  output logic                  last_o
);

  localparam int IDX_W = $clog2(vector_count(SWEEP_BITS));

  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;

  // Next index: clear wins over advance so a restart always begins at vector 0.
  always_comb begin
    idx_d = idx_q;
    if (clear_i) begin
      idx_d = '0;
    end else if (advance_i) begin
      idx_d = idx_q + 1'b1;
    end
  end

  // Index register; the operand outputs are plain slices of it, hence registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign b_o    = idx_q[SWEEP_BITS-1:0];
  assign a_o    = idx_q[2*SWEEP_BITS-1:SWEEP_BITS];
  assign cin_o  = idx_q[2*SWEEP_BITS];
  assign last_o = &idx_q;

endmodule

// File: rtl/adder_bist_checker.sv
// Built-in self-check engine for a combinational WIDTH-bit adder. Sweeps all
// small operands and carry-in values, compares the adder's {cout, sum}
// against A+B+cin and reports error count, first failing vector and pass/done.
module adder_bist_checker
  import adder_bist_defs::*;
#(
  parameter int WIDTH      = 32,
  parameter int SWEEP_BITS = 4,
  parameter int SETTLE     = 1,
  parameter int ERR_W      = DEFAULT_ERR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [WIDTH-1:0]      dut_a,
  output logic [WIDTH-1:0]      dut_b,
  output logic                  dut_cin,
  input  logic [WIDTH-1:0]      dut_s,
  input  logic                  dut_cout,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_W-1:0]      err_count,
  output logic                  fail_valid,
  output logic [SWEEP_BITS-1:0] fail_a,
  output logic [SWEEP_BITS-1:0] fail_b,
  output logic                  fail_cin
);

  // Settle counter runs 0..SETTLE-1 while the operands are held.
  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE - 1);

  bist_state_e           state_q;
  logic [SET_W-1:0]      settle_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  pass_q;
  logic [ERR_W-1:0]      err_count_q;
  logic [ERR_W-1:0]      err_count_d;
  logic                  fail_valid_q;
  logic [SWEEP_BITS-1:0] fail_a_q;
  logic [SWEEP_BITS-1:0] fail_b_q;
  logic                  fail_cin_q;

  logic [SWEEP_BITS-1:0] gen_a;
  logic [SWEEP_BITS-1:0] gen_b;
  logic                  gen_cin;
  logic                  gen_last;
  logic                  gen_clear;
  logic                  gen_advance;
  logic                  start_ok;
  logic [WIDTH:0]        expected_sum;
  logic                  mismatch;

  adder_vector_gen #(
    .SWEEP_BITS(SWEEP_BITS)
  ) u_vector_gen (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (gen_clear),
    .advance_i(gen_advance),
    .a_o      (gen_a),
    .b_o      (gen_b),
    .cin_o    (gen_cin),
    .last_o   (gen_last)
  );

  // Operands come straight from the generator's index register, so they only
  // move on the start edge and on the CHECK exit edge that enters APPLY.
  assign dut_a   = WIDTH'(gen_a);
  assign dut_b   = WIDTH'(gen_b);
  assign dut_cin = gen_cin;

  // Start is honoured only when no sweep is running.
  assign start_ok    = start && ((state_q == IDLE) || (state_q == DONE));
  assign gen_clear   = start_ok;
  assign gen_advance = (state_q == CHECK) && !gen_last;

  // Reference result is one bit wider than the operands; its MSB is the carry.
  assign expected_sum = {1'b0, dut_a} + {1'b0, dut_b} + {{WIDTH{1'b0}}, dut_cin};
  assign mismatch     = ({dut_cout, dut_s} != expected_sum);

  // Saturating error count update for the vector being checked this cycle.
  always_comb begin
    err_count_d = err_count_q;
    if ((state_q == CHECK) && mismatch && !(&err_count_q)) begin
      err_count_d = err_count_q + 1'b1;
    end
  end

  // Sweep controller with registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      settle_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_count_q  <= '0;
      fail_valid_q <= 1'b0;
      fail_a_q     <= '0;
      fail_b_q     <= '0;
      fail_cin_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q      <= APPLY;
            settle_q     <= '0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_count_q  <= '0;
            fail_valid_q <= 1'b0;
            fail_a_q     <= '0;
            fail_b_q     <= '0;
            fail_cin_q   <= 1'b0;
          end
        end
        APPLY: begin
          if (settle_q == SETTLE_LAST) begin
            settle_q <= '0;
            state_q  <= CHECK;
          end else begin
            settle_q <= settle_q + 1'b1;
          end
        end
        CHECK: begin
          err_count_q <= err_count_d;
          if (mismatch && !fail_valid_q) begin
            fail_valid_q <= 1'b1;
            fail_a_q     <= gen_a;
            fail_b_q     <= gen_b;
            fail_cin_q   <= gen_cin;
          end
          if (gen_last) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_count_d == '0);
          end else begin
            state_q <= APPLY;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_count_q;
  assign fail_valid = fail_valid_q;
  assign fail_a     = fail_a_q;
  assign fail_b     = fail_b_q;
  assign fail_cin   = fail_cin_q;

endmodule

// File: tb/tb_adder_bist_checker.sv
// Self-checking bench: a behavioural adder with selectable faults feeds the
// checker (SETTLE=1); a second instance (SETTLE=3) drives a fault-free adder.
module tb_adder_bist_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        start3 = 1'b0;

  logic [31:0] dut_a, dut_b, dut_s;
  logic        dut_cin, dut_cout;
  logic        busy, done, pass, fail_valid, fail_cin;
  logic [15:0] err_count;
  logic [3:0]  fail_a, fail_b;

  logic [31:0] a3, b3, s3;
  logic        cin3, cout3;
  logic        busy3, done3, pass3, fv3, fc3;
  logic [15:0] err3;
  logic [3:0]  fa3, fb3;

  int checks = 0;
  int failures = 0;

  int fault_mode = 0;
  bit fault_mask [512];
  int fault_bit  [512];

  int hold3 = 0;
  int viol3 = 0;
  int changes3 = 0;
  bit in_sweep3 = 1'b0;
  logic [64:0] prev3;

  always #5 clk = ~clk;

  adder_bist_checker #(.WIDTH(32), .SWEEP_BITS(4), .SETTLE(1), .ERR_W(16)) dut (
    .clk(clk), .reset(reset), .start(start),
    .dut_a(dut_a), .dut_b(dut_b), .dut_cin(dut_cin),
    .dut_s(dut_s), .dut_cout(dut_cout),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_valid(fail_valid), .fail_a(fail_a), .fail_b(fail_b), .fail_cin(fail_cin)
  );

  adder_bist_checker #(.WIDTH(32), .SWEEP_BITS(4), .SETTLE(3), .ERR_W(16)) dut3 (
    .clk(clk), .reset(reset), .start(start3),
    .dut_a(a3), .dut_b(b3), .dut_cin(cin3),
    .dut_s(s3), .dut_cout(cout3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
    .fail_valid(fv3), .fail_a(fa3), .fail_b(fb3), .fail_cin(fc3)
  );

  // Behavioural adder under test with optional planted faults.
  logic [32:0] sum_m;
  logic [8:0]  vidx;
  always_comb begin
    vidx  = {dut_cin, dut_a[3:0], dut_b[3:0]};
    sum_m = {1'b0, dut_a} + {1'b0, dut_b} + {32'd0, dut_cin};
    case (fault_mode)
      1: sum_m[0] = 1'b0;
      2: sum_m[32] = 1'b1;
      3: if (fault_mask[vidx]) sum_m = sum_m ^ (33'd1 << fault_bit[vidx]);
      default: ;
    endcase
  end
  assign dut_s    = sum_m[31:0];
  assign dut_cout = sum_m[32];

  // Fault-free adder for the slow-settle instance.
  assign {cout3, s3} = {1'b0, a3} + {1'b0, b3} + {32'd0, cin3};

  // Each vector of the SETTLE=3 sweep must be held for exactly 4 cycles.
  always @(negedge clk) begin
    if (busy3) begin
      if (!in_sweep3) begin
        in_sweep3 = 1'b1;
        hold3 = 1;
      end else if ({a3, b3, cin3} != prev3) begin
        if (hold3 != 4) viol3++;
        changes3++;
        hold3 = 1;
      end else begin
        hold3++;
      end
      prev3 = {a3, b3, cin3};
    end else if (in_sweep3) begin
      if (hold3 != 4) viol3++;
      in_sweep3 = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: walk every vector in sweep order and decide from the fault
  // rules whether the adder result differs from a+b+cin.
  task automatic ref_model(input int mode, output int errs, output bit fv,
                           output int fa, output int fb, output int fc);
    errs = 0; fv = 0; fa = 0; fb = 0; fc = 0;
    for (int c = 0; c < 2; c++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++) begin
          int truth;
          bit bad;
          truth = a + b + c;
          case (mode)
            1: bad = (truth % 2) == 1;
            2: bad = 1'b1;
            3: bad = fault_mask[c * 256 + a * 16 + b];
            default: bad = 1'b0;
          endcase
          if (bad) begin
            errs++;
            if (!fv) begin
              fv = 1'b1; fa = a; fb = b; fc = c;
            end
          end
        end
  endtask

  task automatic check_all_zero(input string pfx);
    chk({pfx, "_dut_a"}, dut_a, 0);
    chk({pfx, "_dut_b"}, dut_b, 0);
    chk({pfx, "_dut_cin"}, dut_cin, 0);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_done"}, done, 0);
    chk({pfx, "_pass"}, pass, 0);
    chk({pfx, "_err"}, err_count, 0);
    chk({pfx, "_fv"}, fail_valid, 0);
    chk({pfx, "_fail_vec"}, {fail_cin, fail_a, fail_b}, 0);
  endtask

  // One full sweep; sel picks the instance, poke_at pulses start mid-sweep.
  task automatic run_sweep(input int sel, input int poke_at, input int mode);
    int settle, exp_cycles, n, errs, fa, fb, fc;
    bit fv;
    settle = sel ? 3 : 1;
    exp_cycles = 512 * (settle + 1);
    ref_model(mode, errs, fv, fa, fb, fc);
    repeat ($urandom_range(0, 5)) @(negedge clk);
    @(negedge clk);
    if (sel) start3 = 1'b1; else start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    start3 = 1'b0;
    chk("start_busy", sel ? busy3 : busy, 1);
    chk("start_done_clr", sel ? done3 : done, 0);
    chk("start_err_clr", sel ? err3 : err_count, 0);
    chk("start_fv_clr", sel ? fv3 : fail_valid, 0);
    n = 0;
    while (!(sel ? done3 : done) && n < exp_cycles + 50) begin
      @(posedge clk);
      n++;
      #1;
      if (sel == 0) start = (n == poke_at);
    end
    start = 1'b0;
    chk("cycles", n, exp_cycles);
    chk("done", sel ? done3 : done, 1);
    chk("busy_end", sel ? busy3 : busy, 0);
    chk("pass", sel ? pass3 : pass, (errs == 0));
    chk("err_count", sel ? err3 : err_count, errs);
    chk("fail_valid", sel ? fv3 : fail_valid, fv);
    chk("fail_a", sel ? fa3 : fail_a, fa);
    chk("fail_b", sel ? fb3 : fail_b, fb);
    chk("fail_cin", sel ? fc3 : fail_cin, fc);
    $display("sweep sel=%0d mode=%0d cycles=%0d err=%0d pass=%0b first=(a%0d b%0d c%0d)",
             sel, mode, n, sel ? err3 : err_count, sel ? pass3 : pass,
             sel ? fa3 : fail_a, sel ? fb3 : fail_b, sel ? fc3 : fail_cin);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero("idle");

    fault_mode = 0; run_sweep(0, -1, 0);
    fault_mode = 1; run_sweep(0, -1, 1);
    fault_mode = 0; run_sweep(0, -1, 0);   // restart from DONE clears results
    fault_mode = 2; run_sweep(0, -1, 2);
    fault_mode = 0; run_sweep(0, 50, 0);   // start while busy is ignored

    for (int r = 0; r < 3; r++) begin
      for (int v = 0; v < 512; v++) begin
        fault_mask[v] = ($urandom_range(0, 63) == 0);
        fault_bit[v]  = $urandom_range(0, 32);
      end
      fault_mode = 3;
      run_sweep(0, -1, 3);
    end

    // Reset in the middle of a failing sweep discards everything.
    fault_mode = 1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("mid_reset");
    reset = 1'b0;
    fault_mode = 0;
    run_sweep(0, -1, 0);

    run_sweep(1, -1, 0);
    @(negedge clk);
    chk("settle3_hold_viol", viol3, 0);
    chk("settle3_changes", changes3, 511);
    $display("settle3 hold_violations=%0d vector_changes=%0d", viol3, changes3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
